// File: rtl/adc_sample_scheduler.sv
// Conversion scheduler for the thermocouple ADC: periodic or one-shot batches of
// 2^n conversions, averaged and published to the host register file.
//
// state   | meaning
// IDLE    | no batch; waiting for tick, oneshot or pending request
// START   | batch active; issue adc_start once the SPI master is free
// WAIT    | conversion outstanding; accumulate on adc_done or time out
// PUBLISH | result/result_valid presented this cycle; pending batch may follow
module adc_sample_scheduler #(
  parameter int DATA_W   = 12,
  parameter int PERIOD_W = 16,
  parameter int TIMEOUT  = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic                cfg_enable,
  input  logic [PERIOD_W-1:0] cfg_period,
  input  logic [1:0]          cfg_avg_log2,
  input  logic                oneshot,
  output logic                adc_start,
  input  logic                adc_busy,
  input  logic                adc_done,
  input  logic [DATA_W-1:0]   adc_data,
  input  logic                adc_fault,
  output logic [DATA_W-1:0]   result,
  output logic                result_valid,
  output logic                result_fault,
  output logic                busy,
  output logic                overrun,
  input  logic                ovr_clr
);

  localparam int ACC_W = DATA_W + 3;
  localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_START   = 2'd1;
  localparam logic [1:0] S_WAIT    = 2'd2;
  localparam logic [1:0] S_PUBLISH = 2'd3;

  logic [1:0]          state;
  logic [PERIOD_W-1:0] tmr;
  logic [ACC_W-1:0]    acc;
  logic [3:0]          cnt;
  logic [1:0]          n_lat;
  logic                fault_or;
  logic                pending;
  logic [TO_W-1:0]     wait_cnt;

  logic                run;
  logic                tick;
  logic                trig;
  logic                start_batch;
  logic                done_last;
  logic                timed_out;
  logic [ACC_W-1:0]    acc_sum;

  assign run  = cfg_enable & ena;
  // >= rather than == so a period shrunk mid-count still wraps promptly
  assign tick = run & ((cfg_period <= PERIOD_W'(1)) | (tmr >= cfg_period - PERIOD_W'(1)));
  assign trig = tick | oneshot | pending;

  // A pending or fresh oneshot during PUBLISH chains straight into the next batch
  assign start_batch = ena & (((state == S_IDLE) & trig) |
                              ((state == S_PUBLISH) & (pending | oneshot)));

  assign acc_sum   = acc + ACC_W'(adc_data);
  assign done_last = (cnt + 4'd1) == (4'd1 << n_lat);
  assign timed_out = wait_cnt == TO_W'(TIMEOUT - 1);
  assign busy      = state != S_IDLE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr <= '0;
    end else if (!run || tick) begin
      tmr <= '0;
    end else begin
      tmr <= tmr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (tick && state != S_IDLE) begin
      overrun <= 1'b1;
    end else if (ovr_clr) begin
      overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= 1'b0;
    end else if (!ena || start_batch) begin
      pending <= 1'b0;
    end else if (oneshot && state != S_IDLE) begin
      pending <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      adc_start    <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      result_fault <= 1'b0;
      acc          <= '0;
      cnt          <= '0;
      n_lat        <= '0;
      fault_or     <= 1'b0;
      wait_cnt     <= '0;
    end else begin
      adc_start    <= 1'b0;
      result_valid <= 1'b0;
      if (!ena) begin
        state    <= S_IDLE;
        acc      <= '0;
        cnt      <= '0;
        fault_or <= 1'b0;
        wait_cnt <= '0;
      end else begin
        case (state)
          S_IDLE, S_PUBLISH: begin
            if (start_batch) begin
              state    <= S_START;
              n_lat    <= cfg_avg_log2;
              acc      <= '0;
              cnt      <= '0;
              fault_or <= 1'b0;
            end else begin
              state <= S_IDLE;
            end
          end
          S_START: begin
            if (!adc_busy) begin
              adc_start <= 1'b1;
              wait_cnt  <= '0;
              state     <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (adc_done) begin
              acc      <= acc_sum;
              fault_or <= fault_or | adc_fault;
              cnt      <= cnt + 4'd1;
              if (done_last) begin
                result       <= DATA_W'(acc_sum >> n_lat);
                result_fault <= fault_or | adc_fault;
                result_valid <= 1'b1;
                state        <= S_PUBLISH;
              end else begin
                state <= S_START;
              end
            end else if (timed_out) begin
              // result keeps the last good average; only the fault flag reports the loss
              result_fault <= 1'b1;
              result_valid <= 1'b1;
              state        <= S_PUBLISH;
            end else begin
              wait_cnt <= wait_cnt + 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/adc_sample_scheduler.md
Name: adc_sample_scheduler

Overview:
- Sequences the ADC SPI master in the thermocouple design.
- Issues conversion starts periodically (continuous mode) or on host one-shot request, and oversamples by averaging 2^n conversions.
- Publishes an averaged result with valid and fault flags to the host SPI register file.
- Sits between the host-side config registers and the ADC SPI master that drives the ADC SPI pins.

Parameters:
- DATA_W, 12, ADC sample width.
- PERIOD_W, 16, width of sample-period config.
- TIMEOUT, 1024, max cycles in WAIT before the batch is aborted.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  design enable; low forces abort to IDLE
- cfg_enable  in  1  continuous-mode enable
- cfg_period  in  PERIOD_W  clocks between periodic triggers
- cfg_avg_log2  in  2  average 2^n conversions, n=0..3
- oneshot  in  1  single-cycle host request for one batch
- adc_start  out  1  single-cycle start pulse to ADC SPI master
- adc_busy  in  1  ADC SPI master transaction in progress
- adc_done  in  1  single-cycle; adc_data/adc_fault valid
- adc_data  in  DATA_W  conversion result
- adc_fault  in  1  sensor fault (open thermocouple), valid with adc_done
- result  out  DATA_W  last averaged result
- result_valid  out  1  single-cycle pulse on publish
- result_fault  out  1  fault status of last published batch
- busy  out  1  high when state != IDLE
- overrun  out  1  sticky; periodic tick dropped because a batch was in progress
- ovr_clr  in  1  clears overrun

Behaviour:
- Reset: state IDLE; all outputs 0; timer, accumulator, counts and pending flag 0.
- FSM states: IDLE, START, WAIT, PUBLISH.
- Timer: runs only when cfg_enable=1 and ena=1. Counts 0..cfg_period-1 and wraps; a tick fires on the wrap cycle. cfg_period 0 or 1 gives a tick every cycle. cfg_enable=0 holds the timer at 0.
- Trigger is tick, oneshot, or the pending flag.
- IDLE with trigger: go to START, latch n=cfg_avg_log2, clear accumulator and fault OR, clear pending. A simultaneous tick and oneshot start a single batch.
- START: if adc_busy=0, assert adc_start for exactly 1 cycle and go to WAIT. Otherwise hold in START with adc_start=0.
- Latency: trigger in IDLE at cycle t gives adc_start at t+2 when adc_busy=0.
- WAIT on adc_done: acc += adc_data (accumulator width DATA_W+3, no overflow), fault_or |= adc_fault, count+1. If count==2^n go to PUBLISH, else go to START.
- WAIT timeout: TIMEOUT cycles without adc_done. Go to PUBLISH with timeout flag set; result holds its previous value and result_fault=1.
- PUBLISH: result = acc >> n (truncate); result_fault = fault_or; result_valid=1 for 1 cycle; then go to IDLE. result_valid appears 1 cycle after the final adc_done.
- oneshot outside IDLE sets pending (single slot; repeats merge). The pending batch starts on the cycle after PUBLISH.
- Periodic tick outside IDLE is dropped and sets overrun. If ovr_clr and overrun-set happen in the same cycle, set wins.
- adc_done outside WAIT is ignored.
- cfg_avg_log2 change mid-batch has no effect until the next batch. cfg_enable falling mid-batch: the batch completes.
- ena low: synchronous abort to IDLE next cycle; clear pending, accumulator and timer; no result_valid; result and result_fault hold.

Test Plan:
- Reset mid-batch (rst_n low in WAIT) -> all outputs 0 immediately, state IDLE; no adc_start after release until a trigger.
- oneshot, n=0, ADC model returns 0x5A3 after 20 cycles -> adc_start 2 cycles after oneshot; result=0x5A3, result_valid 1 cycle after adc_done, result_fault=0.
- n=2, samples 100/101/102/104 -> 4 adc_start pulses; result=101 (407>>2); exactly 1 result_valid pulse.
- cfg_enable=1, cfg_period=50, conversions take 80 cycles -> overrun set; ovr_clr clears it; every other tick starts a batch.
- adc_busy held high for 10 cycles at START -> adc_start delayed until busy falls, then exactly 1 pulse. ADC never returns adc_done -> after 1024 cycles result_valid with result_fault=1 and result unchanged.
- oneshot during batch plus adc_fault=1 on 2nd of 2 samples -> first publish has result_fault=1; second batch starts the cycle after PUBLISH. ena low mid-WAIT -> busy=0 next cycle and no result_valid.
